// File: rtl/mips_mc_controller.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives every datapath enable and mux select, stalling on the memory-ready handshake.
module mips_mc_controller #(
  parameter int STATEW = 4
) (
  input  logic              clk,
  input  logic              ci_rst_n,
  input  logic [5:0]        ci_op,
  input  logic [5:0]        ci_funct,
  input  logic              ci_zero,
  input  logic              ci_memready,
  output logic              co_pcen,
  output logic              co_iord,
  output logic              co_memwrite,
  output logic              co_irwrite,
  output logic              co_regdst,
  output logic              co_memtoreg,
  output logic              co_regwrite,
  output logic              co_alusrca,
  output logic [1:0]        co_alusrcb,
  output logic [2:0]        co_alucontrol,
  output logic [1:0]        co_pcsrc,
  output logic              co_illegal,
  output logic [STATEW-1:0] co_state
);

  typedef enum logic [STATEW-1:0] {
    FETCH   = 'd0,
    DECODE  = 'd1,
    MEMADR  = 'd2,
    MEMRD   = 'd3,
    MEMWB   = 'd4,
    MEMWR   = 'd5,
    RTYPEEX = 'd6,
    ALUWB   = 'd7,
    BEQEX   = 'd8,
    ADDIEX  = 'd9,
    ADDIWB  = 'd10,
    JEX     = 'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state, nxt;
  logic   pcwrite, branch, irw, mw, rw, ill;

  function automatic logic funct_ok(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

  always_ff @(posedge clk or negedge ci_rst_n) begin
    if (!ci_rst_n) state <= FETCH;
    else           state <= nxt;
  end

  always_comb begin
    nxt           = FETCH;
    pcwrite       = 1'b0;
    branch        = 1'b0;
    irw           = 1'b0;
    mw            = 1'b0;
    rw            = 1'b0;
    ill           = 1'b0;
    co_iord       = 1'b0;
    co_regdst     = 1'b0;
    co_memtoreg   = 1'b0;
    co_alusrca    = 1'b0;
    co_alusrcb    = 2'b00;
    co_alucontrol = 3'b000;
    co_pcsrc      = 2'b00;
    case (state)
      FETCH: begin
        co_alusrcb    = 2'b01;
        co_alucontrol = ALU_ADD;
        irw           = ci_memready;
        pcwrite       = ci_memready;
        nxt           = ci_memready ? DECODE : FETCH;
      end
      DECODE: begin
        // Branch target computed speculatively into ALUOut
        co_alusrcb    = 2'b11;
        co_alucontrol = ALU_ADD;
        case (ci_op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_RTYPE: begin
            if (funct_ok(ci_funct)) nxt = RTYPEEX;
            else                    ill = 1'b1;
          end
          OP_BEQ:  nxt = BEQEX;
          OP_ADDI: nxt = ADDIEX;
          OP_J:    nxt = JEX;
          default: ill = 1'b1;
        endcase
      end
      MEMADR: begin
        co_alusrca    = 1'b1;
        co_alusrcb    = 2'b10;
        co_alucontrol = ALU_ADD;
        nxt           = (ci_op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        co_iord = 1'b1;
        nxt     = ci_memready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        co_memtoreg = 1'b1;
        rw          = 1'b1;
      end
      MEMWR: begin
        // Strobe held for the whole wait so the memory sees a stable request
        co_iord = 1'b1;
        mw      = 1'b1;
        nxt     = ci_memready ? FETCH : MEMWR;
      end
      RTYPEEX: begin
        co_alusrca = 1'b1;
        case (ci_funct)
          FN_ADD:  co_alucontrol = ALU_ADD;
          FN_SUB:  co_alucontrol = ALU_SUB;
          FN_AND:  co_alucontrol = ALU_AND;
          FN_OR:   co_alucontrol = ALU_OR;
          FN_SLT:  co_alucontrol = ALU_SLT;
          default: co_alucontrol = ALU_ADD;
        endcase
        nxt = ALUWB;
      end
      ALUWB: begin
        co_regdst = 1'b1;
        rw        = 1'b1;
      end
      BEQEX: begin
        co_alusrca    = 1'b1;
        co_alucontrol = ALU_SUB;
        co_pcsrc      = 2'b01;
        branch        = 1'b1;
      end
      ADDIEX: begin
        co_alusrca    = 1'b1;
        co_alusrcb    = 2'b10;
        co_alucontrol = ALU_ADD;
        nxt           = ADDIWB;
      end
      ADDIWB: rw = 1'b1;
      JEX: begin
        co_pcsrc = 2'b10;
        pcwrite  = 1'b1;
      end
      default: nxt = FETCH;
    endcase
  end

  // Strobes are gated by reset so a pending write drops in the same cycle
  assign co_pcen     = ci_rst_n & (pcwrite | (branch & ci_zero));
  assign co_irwrite  = ci_rst_n & irw;
  assign co_memwrite = ci_rst_n & mw;
  assign co_regwrite = ci_rst_n & rw;
  assign co_illegal  = ci_rst_n & ill;
  assign co_state    = state;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Scoreboard bench for mips_mc_controller: directed per-cycle vectors push expected
// outputs into a queue; a negedge monitor pops and compares.
module tb_mips_mc_controller;
  logic       clk = 1'b0;
  logic       ci_rst_n = 1'b0;
  logic [5:0] ci_op = 6'd0, ci_funct = 6'd0;
  logic       ci_zero = 1'b0, ci_memready = 1'b1;
  logic       co_pcen, co_iord, co_memwrite, co_irwrite, co_regdst, co_memtoreg;
  logic       co_regwrite, co_alusrca, co_illegal;
  logic [1:0] co_alusrcb, co_pcsrc;
  logic [2:0] co_alucontrol;
  logic [3:0] co_state;

  int n_chk = 0;
  int n_fail = 0;

  mips_mc_controller #(.STATEW(4)) dut (
    .clk(clk), .ci_rst_n(ci_rst_n), .ci_op(ci_op), .ci_funct(ci_funct),
    .ci_zero(ci_zero), .ci_memready(ci_memready), .co_pcen(co_pcen),
    .co_iord(co_iord), .co_memwrite(co_memwrite), .co_irwrite(co_irwrite),
    .co_regdst(co_regdst), .co_memtoreg(co_memtoreg), .co_regwrite(co_regwrite),
    .co_alusrca(co_alusrca), .co_alusrcb(co_alusrcb), .co_alucontrol(co_alucontrol),
    .co_pcsrc(co_pcsrc), .co_illegal(co_illegal), .co_state(co_state)
  );

  always #5 clk = ~clk;

  // -1 in any field means "not checked in this cycle"
  typedef struct {
    string nm;
    int st, pcen, irw, mw, rw, ill, iord, regdst, m2r, asa, asb, aluc, pcsrc;
  } exp_t;

  exp_t q[$];

  function automatic exp_t e(int st, int pcen, int irw, int mw, int rw, int ill);
    exp_t x;
    x.nm = ""; x.st = st; x.pcen = pcen; x.irw = irw; x.mw = mw; x.rw = rw; x.ill = ill;
    x.iord = -1; x.regdst = -1; x.m2r = -1; x.asa = -1; x.asb = -1; x.aluc = -1; x.pcsrc = -1;
    return x;
  endfunction

  function automatic exp_t ef(int mr);
    exp_t x;
    x = e(0, mr, mr, 0, 0, 0);
    x.iord = 0; x.asa = 0; x.asb = 1; x.aluc = 2; x.pcsrc = 0;
    return x;
  endfunction

  task automatic chk(string nm, string f, int act, int exp);
    if (exp >= 0) begin
      n_chk++;
      if (act != exp) begin
        n_fail++;
        $display("FAIL %s.%s: got %0d expected %0d", nm, f, act, exp);
      end
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      chk(x.nm, "state",   int'(co_state),      x.st);
      chk(x.nm, "pcen",    int'(co_pcen),       x.pcen);
      chk(x.nm, "irwrite", int'(co_irwrite),    x.irw);
      chk(x.nm, "memwr",   int'(co_memwrite),   x.mw);
      chk(x.nm, "regwr",   int'(co_regwrite),   x.rw);
      chk(x.nm, "illegal", int'(co_illegal),    x.ill);
      chk(x.nm, "iord",    int'(co_iord),       x.iord);
      chk(x.nm, "regdst",  int'(co_regdst),     x.regdst);
      chk(x.nm, "memtoreg",int'(co_memtoreg),   x.m2r);
      chk(x.nm, "alusrca", int'(co_alusrca),    x.asa);
      chk(x.nm, "alusrcb", int'(co_alusrcb),    x.asb);
      chk(x.nm, "aluctl",  int'(co_alucontrol), x.aluc);
      chk(x.nm, "pcsrc",   int'(co_pcsrc),      x.pcsrc);
    end
  end

  task automatic drive(string nm, logic rst, logic [5:0] op, logic [5:0] fn,
                       logic z, logic mr, exp_t x);
    @(posedge clk); #1;
    ci_rst_n = rst; ci_op = op; ci_funct = fn; ci_zero = z; ci_memready = mr;
    x.nm = nm;
    q.push_back(x);
  endtask

  task automatic do_fetch(string nm, logic [5:0] op, logic [5:0] fn);
    drive({nm, "/fetch"}, 1'b1, op, fn, 1'b0, 1'b1, ef(1));
  endtask

  task automatic do_decode(string nm, logic [5:0] op, logic [5:0] fn);
    exp_t x;
    x = e(1, 0, 0, 0, 0, 0);
    x.asa = 0; x.asb = 3; x.aluc = 2;
    drive({nm, "/decode"}, 1'b1, op, fn, 1'b0, 1'b1, x);
  endtask

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, J = 6'b000010;

  initial begin
    exp_t x;
    logic [5:0] fns [5];
    int alus [5];
    fns[0] = 6'b100000; alus[0] = 2;
    fns[1] = 6'b100010; alus[1] = 6;
    fns[2] = 6'b100100; alus[2] = 0;
    fns[3] = 6'b100101; alus[3] = 1;
    fns[4] = 6'b101010; alus[4] = 7;

    // reset: strobes forced low even though memready=1
    x = ef(1); x.pcen = 0; x.irw = 0;
    drive("reset", 1'b0, 6'd0, 6'd0, 1'b0, 1'b1, x);
    drive("fetch_stall", 1'b1, LW, 6'd0, 1'b0, 1'b0, ef(0));

    // lw with 2 wait cycles in MEMRD: 0,1,2,3,3,3,4,0
    do_fetch("lw", LW, 6'd0);
    do_decode("lw", LW, 6'd0);
    x = e(2, 0, 0, 0, 0, 0); x.asa = 1; x.asb = 2; x.aluc = 2;
    drive("lw/memadr", 1'b1, LW, 6'd0, 1'b0, 1'b1, x);
    x = e(3, 0, 0, 0, 0, 0); x.iord = 1; x.m2r = 0;
    drive("lw/memrd_w1", 1'b1, LW, 6'd0, 1'b0, 1'b0, x);
    drive("lw/memrd_w2", 1'b1, LW, 6'd0, 1'b0, 1'b0, x);
    drive("lw/memrd_ok", 1'b1, LW, 6'd0, 1'b0, 1'b1, x);
    x = e(4, 0, 0, 0, 1, 0); x.regdst = 0; x.m2r = 1;
    drive("lw/memwb", 1'b1, LW, 6'd0, 1'b0, 1'b1, x);

    // R-type sweep
    for (int i = 0; i < 5; i++) begin
      do_fetch("rtype", 6'd0, fns[i]);
      do_decode("rtype", 6'd0, fns[i]);
      x = e(6, 0, 0, 0, 0, 0); x.asa = 1; x.asb = 0; x.aluc = alus[i];
      drive("rtype/ex", 1'b1, 6'd0, fns[i], 1'b0, 1'b1, x);
      x = e(7, 0, 0, 0, 1, 0); x.regdst = 1; x.m2r = 0;
      drive("rtype/aluwb", 1'b1, 6'd0, fns[i], 1'b0, 1'b1, x);
    end

    // beq taken / not taken
    for (int z = 1; z >= 0; z--) begin
      do_fetch("beq", BEQ, 6'd0);
      do_decode("beq", BEQ, 6'd0);
      x = e(8, z, 0, 0, 0, 0); x.asa = 1; x.asb = 0; x.aluc = 6; x.pcsrc = 1;
      drive("beq/ex", 1'b1, BEQ, 6'd0, 1'(z), 1'b1, x);
    end

    // addi
    do_fetch("addi", ADDI, 6'd0);
    do_decode("addi", ADDI, 6'd0);
    x = e(9, 0, 0, 0, 0, 0); x.asa = 1; x.asb = 2; x.aluc = 2;
    drive("addi/ex", 1'b1, ADDI, 6'd0, 1'b0, 1'b1, x);
    x = e(10, 0, 0, 0, 1, 0); x.regdst = 0; x.m2r = 0;
    drive("addi/wb", 1'b1, ADDI, 6'd0, 1'b0, 1'b1, x);

    // sw with 3 wait cycles: memwrite high 4 consecutive cycles
    do_fetch("sw", SW, 6'd0);
    do_decode("sw", SW, 6'd0);
    x = e(2, 0, 0, 0, 0, 0); x.asa = 1; x.asb = 2;
    drive("sw/memadr", 1'b1, SW, 6'd0, 1'b0, 1'b1, x);
    x = e(5, 0, 0, 1, 0, 0); x.iord = 1;
    for (int i = 0; i < 3; i++) drive("sw/memwr_wait", 1'b1, SW, 6'd0, 1'b0, 1'b0, x);
    drive("sw/memwr_ok", 1'b1, SW, 6'd0, 1'b0, 1'b1, x);

    // sw interrupted by reset during the wait
    do_fetch("swrst", SW, 6'd0);
    do_decode("swrst", SW, 6'd0);
    x = e(2, 0, 0, 0, 0, 0);
    drive("swrst/memadr", 1'b1, SW, 6'd0, 1'b0, 1'b1, x);
    x = e(5, 0, 0, 1, 0, 0); x.iord = 1;
    drive("swrst/memwr_wait", 1'b1, SW, 6'd0, 1'b0, 1'b0, x);
    x = ef(0);
    drive("swrst/reset", 1'b0, SW, 6'd0, 1'b0, 1'b0, x);

    // illegal opcode, then illegal funct
    do_fetch("ill_op", 6'b111111, 6'd0);
    drive("ill_op/decode", 1'b1, 6'b111111, 6'd0, 1'b0, 1'b1, e(1, 0, 0, 0, 0, 1));
    do_fetch("ill_fn", 6'd0, 6'd0);
    drive("ill_fn/decode", 1'b1, 6'd0, 6'd0, 1'b0, 1'b1, e(1, 0, 0, 0, 0, 1));

    // j
    do_fetch("j", J, 6'd0);
    do_decode("j", J, 6'd0);
    x = e(11, 1, 0, 0, 0, 0); x.pcsrc = 2;
    drive("j/ex", 1'b1, J, 6'd0, 1'b0, 1'b1, x);
    do_fetch("end", 6'd0, 6'b100000);

    repeat (3) @(posedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_mc_controller.md
# mips_mc_controller

Main control unit for the multicycle integer MIPS core. It decodes the opcode and funct fields latched in the instruction register and sequences fetch, decode, execute, memory and writeback one step per clock. It drives every datapath enable and mux select, and stalls on a memory-ready handshake. It supports the single-cycle core's instruction set (add, sub, and, or, slt, lw, sw, beq, addi, j), so the same test programs run on both cores.

## Interface
Parameters:
- STATEW, 4, width of the state register and of co_state.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- ci_rst_n  in  1  reset, asynchronous, active-low.
- ci_op  in  6  instr[31:26] from the instruction register.
- ci_funct  in  6  instr[5:0] from the instruction register.
- ci_zero  in  1  ALU zero flag.
- ci_memready  in  1  unified memory has completed the current read or write.
- co_pcen  out  1  PC register enable.
- co_iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- co_memwrite  out  1  memory write strobe.
- co_irwrite  out  1  instruction register enable.
- co_regdst  out  1  register write destination: 0 = rt, 1 = rd.
- co_memtoreg  out  1  register write data: 0 = ALUOut, 1 = Data.
- co_regwrite  out  1  register file write enable.
- co_alusrca  out  1  ALU A: 0 = PC, 1 = A register.
- co_alusrcb  out  2  ALU B: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- co_alucontrol  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- co_pcsrc  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- co_illegal  out  1  one-cycle pulse when an unsupported opcode or funct is decoded.
- co_state  out  STATEW  current state, for debug and the bench.

## Operation
State encoding (co_state):
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, ALUWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
- Codes 12–15 are unreachable. If entered, they return to FETCH on the next edge with all strobes 0.

State actions and transitions:
- FETCH: iord=0, alusrca=0, alusrcb=01, alu add, pcsrc=00; irwrite = pcwrite = ci_memready. Stays in FETCH while ci_memready=0, otherwise goes to DECODE.
- DECODE: alusrca=0, alusrcb=11, alu add (branch target into ALUOut). Next state by op:
  - 100011 or 101011 → MEMADR
  - 000000 with a supported funct → RTYPEEX
  - 000100 → BEQEX
  - 001000 → ADDIEX
  - 000010 → JEX
  - anything else → FETCH with co_illegal=1 for this cycle.
- MEMADR: alusrca=1, alusrcb=10, alu add. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Holds until ci_memready=1, then goes to MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1 → FETCH.
- MEMWR: iord=1, memwrite=1. Holds until ci_memready=1, then goes to FETCH. memwrite stays high for the whole wait.
- RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct:
  - 100000 → 010
  - 100010 → 110
  - 100100 → 000
  - 100101 → 001
  - 101010 → 111
  - Then → ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1 → FETCH.
- BEQEX: alusrca=1, alusrcb=00, alu sub, pcsrc=01, branch=1 → FETCH.
- ADDIEX: alusrca=1, alusrcb=10, alu add → ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1 → FETCH.
- JEX: pcsrc=10, pcwrite=1 → FETCH.

Output rules:
- co_pcen = pcwrite | (branch & ci_zero), combinational.
- Signals not listed for a state are 0.

## Timing
- Reset: state = FETCH asynchronously on ci_rst_n low. While ci_rst_n=0, co_pcen, co_irwrite, co_regwrite, co_memwrite and co_illegal are forced to 0. All other outputs take their FETCH values.
- The first fetch happens on the first rising edge with ci_rst_n=1 and ci_memready=1.
- Latency in cycles with zero memory wait:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - illegal 2
- Each cycle that ci_memready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Outputs are Moore (function of state), except co_pcen, co_irwrite (ci_memready, ci_zero) and co_illegal (ci_op/ci_funct in DECODE).
- Reset asserted mid-instruction: state returns to FETCH immediately and any pending write strobe drops in the same cycle.

## Test plan
- Reset: ci_rst_n=0 with ci_memready=1 → co_state=0, co_pcen=0, co_irwrite=0. Release → co_pcen=1 and co_irwrite=1 in FETCH, then co_state=1.
- lw (op=100011), ci_memready=1 except 2 wait cycles in MEMRD → states 0,1,2,3,3,3,4,0. co_regwrite=1 and co_memtoreg=1 only in state 4.
- R-type sweep in RTYPEEX:
  - funct=100000/100010/100100/100101/101010 → co_alucontrol=010/110/000/001/111.
  - ALUWB then has co_regdst=1 and co_regwrite=1.
- beq in BEQEX:
  - ci_zero=1 → co_pcen=1, co_pcsrc=01.
  - ci_zero=0 → co_pcen=0.
  - Both cases return to FETCH after 3 cycles.
- sw with ci_memready held 0 for 3 cycles in MEMWR → co_memwrite=1 for 4 consecutive cycles, co_iord=1, then FETCH. Asserting ci_rst_n=0 during the wait drops co_memwrite the same cycle.
- Illegal decode:
  - op=111111 → co_illegal=1 for exactly one cycle in DECODE, next co_state=0, no regwrite or memwrite.
  - op=000000 with funct=000000 behaves the same.
  - j (op=000010) → co_pcsrc=10 and co_pcen=1 in JEX.
